// File: rtl/mp_alu_seq.sv
// Multi-word sequencer that drives an external 16-bit ALU one word per cycle
// and assembles ADD/SUB/AND/XOR/OR/NOT results up to NW words wide.
module mp_alu_seq #(
  parameter int NW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmd,
  input  logic [1:0]       wcnt,
  input  logic [16*NW-1:0] opa,
  input  logic [16*NW-1:0] opb,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_cin,
  input  logic [15:0]      alu_z,
  input  logic             alu_cout,
  output logic [16*NW-1:0] result,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_AND = 3'd2;
  localparam logic [2:0] CMD_XOR = 3'd3;
  localparam logic [2:0] CMD_OR  = 3'd4;
  localparam logic [2:0] CMD_NOT = 3'd5;
  localparam logic [1:0] MAX_K   = 2'(NW - 1);

  state_t           state;
  logic [1:0]       k;
  logic [1:0]       last_k;
  logic [2:0]       cmd_r;
  logic [16*NW-1:0] a_r;
  logic [16*NW-1:0] b_r;
  logic [15:0]      a_word;
  logic [15:0]      b_word;
  logic [1:0]       wcnt_clamped;
  logic             arith;

  assign wcnt_clamped = (wcnt > MAX_K) ? MAX_K : wcnt;
  assign arith        = (cmd_r == CMD_ADD) || (cmd_r == CMD_SUB);

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NW; i++) begin
      if (k == 2'(i)) begin
        a_word = a_r[16*i +: 16];
        b_word = b_r[16*i +: 16];
      end
    end
  end

  // The ALU bus is quiet outside RUN; only the first word of ADD/SUB starts without carry-in.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 4'h0;
    alu_cin = 1'b0;
    if (state == RUN) begin
      alu_a   = a_word;
      alu_b   = (cmd_r == CMD_NOT) ? 16'h0000 : b_word;
      alu_cin = arith && (k != 2'd0) && carry;
      case (cmd_r)
        CMD_ADD: alu_op = (k == 2'd0) ? 4'h2 : 4'h6;
        CMD_SUB: alu_op = (k == 2'd0) ? 4'h3 : 4'h7;
        CMD_AND: alu_op = 4'h8;
        CMD_XOR: alu_op = 4'h9;
        CMD_OR:  alu_op = 4'ha;
        CMD_NOT: alu_op = 4'hb;
        default: alu_op = 4'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= 2'd0;
      last_k <= 2'd0;
      cmd_r  <= 3'd0;
      a_r    <= '0;
      b_r    <= '0;
      result <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd <= CMD_NOT) begin
              cmd_r  <= cmd;
              last_k <= wcnt_clamped;
              a_r    <= opa;
              b_r    <= opb;
              result <= '0;
              carry  <= 1'b0;
              k      <= 2'd0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          for (int i = 0; i < NW; i++) begin
            if (k == 2'(i)) begin
              result[16*i +: 16] <= alu_z;
            end
          end
          carry <= arith ? alu_cout : 1'b0;
          k     <= k + 2'd1;
          if (k == last_k) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Self-checking bench for mp_alu_seq: behavioural ALU, arithmetic reference model
// checked every cycle, directed literal scenarios and randomized traffic.
module tb_mp_alu_seq;

  localparam int NW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       cmd = 3'd0;
  logic [1:0]       wcnt = 2'd0;
  logic [16*NW-1:0] opa = '0;
  logic [16*NW-1:0] opb = '0;
  logic [15:0]      alu_a, alu_b, alu_z;
  logic [3:0]       alu_op;
  logic             alu_cin, alu_cout;
  logic [16*NW-1:0] result;
  logic             carry, busy, done, err;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  mp_alu_seq #(.NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .wcnt(wcnt),
    .opa(opa), .opb(opb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_z(alu_z), .alu_cout(alu_cout),
    .result(result), .carry(carry), .busy(busy), .done(done), .err(err)
  );

  initial forever #5 clk = ~clk;

  // External 16-bit ALU: carry-out on add, borrow-out on subtract.
  always_comb begin
    {alu_cout, alu_z} = 17'd0;
    case (alu_op)
      4'h2: {alu_cout, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h6: {alu_cout, alu_z} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
      4'h3: {alu_cout, alu_z} = {1'b0, alu_a} - {1'b0, alu_b};
      4'h7: {alu_cout, alu_z} = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
      4'h8: alu_z = alu_a & alu_b;
      4'h9: alu_z = alu_a ^ alu_b;
      4'ha: alu_z = alu_a | alu_b;
      4'hb: alu_z = ~alu_a;
      default: {alu_cout, alu_z} = 17'd0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {carry, result} of the operation applied to the low n words only.
  function automatic logic [64:0] partial(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] c, input int n);
    logic [64:0] mask, s;
    logic [63:0] am, bm;
    mask = (65'd1 << (16 * n)) - 65'd1;
    am = a & mask[63:0];
    bm = b & mask[63:0];
    s = '0;
    case (c)
      3'd0: begin
        s = {1'b0, am} + {1'b0, bm};
        s = {s[16*n], s[63:0] & mask[63:0]};
      end
      3'd1: s = {(am < bm), (am - bm) & mask[63:0]};
      3'd2: s = {1'b0, am & bm};
      3'd3: s = {1'b0, am ^ bm};
      3'd4: s = {1'b0, am | bm};
      3'd5: s = {1'b0, ~am & mask[63:0]};
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] expOp(input logic [2:0] c, input int k);
    case (c)
      3'd0: return (k == 0) ? 4'h2 : 4'h6;
      3'd1: return (k == 0) ? 4'h3 : 4'h7;
      3'd2: return 4'h8;
      3'd3: return 4'h9;
      3'd4: return 4'ha;
      3'd5: return 4'hb;
      default: return 4'h0;
    endcase
  endfunction

  // Reference model: phase 0 idle, 1..m_cnt working on word phase-1, m_cnt+1 reporting.
  int          m_phase = 0;
  int          m_cnt = 1;
  int          m_wd = 0;
  logic [2:0]  m_cmd = 3'd0;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    m_err <= 1'b0;
    if (rst) begin
      m_phase <= 0;
      m_wd    <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_cmd   <= 3'd0;
      m_cnt   <= 1;
    end else if (m_phase == 0) begin
      if (start) begin
        if (cmd <= 3'd5) begin
          m_a     <= opa;
          m_b     <= opb;
          m_cmd   <= cmd;
          m_cnt   <= ((int'(wcnt) > NW - 1) ? NW - 1 : int'(wcnt)) + 1;
          m_wd    <= 0;
          m_phase <= 1;
        end else begin
          m_err <= 1'b1;
        end
      end
    end else if (m_phase <= m_cnt) begin
      m_wd    <= m_phase;
      m_phase <= m_phase + 1;
    end else begin
      m_phase <= 0;
    end
  end

  logic [64:0] e_p;
  logic [15:0] e_a, e_b;
  logic [3:0]  e_op;
  logic        e_cin, e_busy, e_done;
  int          e_k;

  always @(negedge clk) begin
    if (mon_en) begin
      e_p    = partial(m_a, m_b, m_cmd, m_wd);
      e_busy = (m_phase != 0);
      e_done = (m_phase == m_cnt + 1);
      e_a = '0; e_b = '0; e_op = '0; e_cin = 1'b0;
      if (m_phase >= 1 && m_phase <= m_cnt) begin
        e_k   = m_phase - 1;
        e_a   = m_a[16*e_k +: 16];
        e_b   = (m_cmd == 3'd5) ? 16'h0 : m_b[16*e_k +: 16];
        e_op  = expOp(m_cmd, e_k);
        e_cin = e_p[64];
      end
      checkOutput("mon_ctl", 128'({busy, done, err}), 128'({e_busy, e_done, m_err}));
      checkOutput("mon_res", 128'({carry, result}), 128'(e_p));
      checkOutput("mon_alu", 128'({alu_a, alu_b, alu_op, alu_cin}), 128'({e_a, e_b, e_op, e_cin}));
    end
  end

  int          cap_lat;
  logic [15:0] cap_ops;
  logic [3:0]  cap_cins;
  logic        cap_err, cap_carry, cap_busy, cap_done;
  logic [63:0] cap_result;

  // Issues one operation and follows it; cycle n=1 is the cycle starting at the accept edge.
  task automatic applyStimulus(input logic [2:0] c, input logic [1:0] w, input logic [63:0] a,
                               input logic [63:0] b, input int inject_at, input int rst_at);
    @(negedge clk);
    start = 1'b1; cmd = c; wcnt = w; opa = a; opb = b;
    cap_lat = -1; cap_ops = '0; cap_cins = '0; cap_err = 1'b0;
    cap_result = '0; cap_carry = 1'b0; cap_busy = 1'b0; cap_done = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (err) cap_err = 1'b1;
      if (busy && !done) begin
        cap_ops  = {cap_ops[11:0], alu_op};
        cap_cins = {cap_cins[2:0], alu_cin};
      end
      if (rst_at != 0 && n == rst_at + 1) begin
        cap_result = result; cap_carry = carry; cap_busy = busy; cap_done = done;
        rst = 1'b0;
        break;
      end
      if (done) begin
        cap_lat = n; cap_result = result; cap_carry = carry;
        break;
      end
      if (n == 1) begin
        start = 1'b0;
        cmd   = 3'($urandom_range(0, 7));
        wcnt  = 2'($urandom_range(0, 3));
        opa   = {$urandom, $urandom};
        opb   = {$urandom, $urandom};
      end
      if (n == inject_at) begin
        start = 1'b1; cmd = 3'd1; wcnt = 2'd0; opa = ~a; opb = b ^ 64'h5a5a;
      end
      if (inject_at != 0 && n == inject_at + 1) start = 1'b0;
      if (n == rst_at) rst = 1'b1;
    end
  endtask

  int rand_done = 0;
  int late_done = 0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    checkOutput("reset_ctl", 128'({busy, done, err}), 128'(3'b000));
    checkOutput("reset_res", 128'({carry, result}), 128'(0));
    checkOutput("reset_alu_op", 128'(alu_op), 128'(0));
    rst = 1'b0;

    applyStimulus(3'd0, 2'd3, 64'h0000_0000_FFFF_FFFF, 64'h1, 0, 0);
    checkOutput("add4_latency", 128'(cap_lat), 128'(5));
    checkOutput("add4_result", 128'(cap_result), 128'(64'h0000_0001_0000_0000));
    checkOutput("add4_carry", 128'(cap_carry), 128'(0));
    checkOutput("add4_op_seq", 128'(cap_ops), 128'(16'h2666));

    applyStimulus(3'd1, 2'd1, 64'h0001_0000, 64'h0000_0001, 0, 0);
    checkOutput("sub2_latency", 128'(cap_lat), 128'(3));
    checkOutput("sub2_result", 128'(cap_result), 128'(64'h0000_FFFF));
    checkOutput("sub2_carry", 128'(cap_carry), 128'(0));
    checkOutput("sub2_cin_seq", 128'(cap_cins), 128'(4'b0001));
    checkOutput("sub2_op_seq", 128'(cap_ops), 128'(16'h0037));

    applyStimulus(3'd0, 2'd0, 64'hFFFF, 64'h0001, 0, 0);
    checkOutput("add1_latency", 128'(cap_lat), 128'(2));
    checkOutput("add1_result", 128'(cap_result), 128'(0));
    checkOutput("add1_carry", 128'(cap_carry), 128'(1));

    applyStimulus(3'd3, 2'd3, 64'hAAAA_5555_FFFF_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    checkOutput("xor4_result", 128'(cap_result), 128'(64'h5555_AAAA_0000_FFFF));
    checkOutput("xor4_carry", 128'(cap_carry), 128'(0));
    checkOutput("xor4_cin_seq", 128'(cap_cins), 128'(0));
    checkOutput("xor4_op_seq", 128'(cap_ops), 128'(16'h9999));

    applyStimulus(3'd0, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 2, 0);
    checkOutput("busy_start_latency", 128'(cap_lat), 128'(5));
    checkOutput("busy_start_result", 128'(cap_result), 128'(64'h2345_6789_ABCD_F001));
    checkOutput("busy_start_no_err", 128'(cap_err), 128'(0));

    @(negedge clk);
    start = 1'b1; cmd = 3'd6;
    @(negedge clk);
    start = 1'b0;
    checkOutput("bad_cmd_err", 128'(err), 128'(1));
    checkOutput("bad_cmd_busy", 128'(busy), 128'(0));
    checkOutput("bad_cmd_result_kept", 128'(result), 128'(64'h2345_6789_ABCD_F001));
    @(negedge clk);
    checkOutput("bad_cmd_err_pulse", 128'(err), 128'(0));

    applyStimulus(3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 2);
    checkOutput("abort_busy", 128'(cap_busy), 128'(0));
    checkOutput("abort_done", 128'(cap_done), 128'(0));
    checkOutput("abort_result", 128'(cap_result), 128'(0));
    checkOutput("abort_carry", 128'(cap_carry), 128'(0));
    repeat (6) begin
      @(negedge clk);
      if (done) late_done++;
    end
    checkOutput("abort_no_done", 128'(late_done), 128'(0));

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) rand_done++;
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) == 0);
      cmd   = 3'($urandom_range(0, 7));
      wcnt  = 2'($urandom_range(0, 3));
      opa   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      opb   = ($urandom_range(0, 3) == 0) ? 64'h1 : {$urandom, $urandom};
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("random_done_seen", 128'(rand_done > 0), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
